uart_core: RTL and testbench

// - Parametrised full-duplex UART; successor to the fixed 8N1 / 115 200 Bd / 50 MHz UART.
// - Adds generic clock/baud/data-width/stop-bit parameters, 16x-oversampled RX with start-glitch rejection,

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_if.sv | 17 +
 rtl/uart_tick_gen.sv | 22 ++
 rtl/uart_core.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tTxState;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } tRxState;

   // Oversample tick divider, rounded to nearest.
   function automatic int calcTickDiv(input int clkFreq, input int baud, input int oversample);
      int den;
      den = baud * oversample;
      return (clkFreq + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_if.sv
// UART user-side bundle: TX valid/ready request, serial pins and RX word/strobe.
interface uart_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] ipTxData;
   logic                 ipTxValid;
   logic                 opTxReady;
   logic                 opTx;
   logic                 ipRx;
   logic [DATA_BITS-1:0] opRxData;
   logic                 opRxValid;
   logic                 opRxFrameErr;
   logic                 opRxParityErr;

   modport master (output ipTxData, ipTxValid, ipRx,
                   input  opTxReady, opTx, opRxData, opRxValid, opRxFrameErr, opRxParityErr);
   modport slave  (input  ipTxData, ipTxValid, ipRx,
                   output opTxReady, opTx, opRxData, opRxValid, opRxFrameErr, opRxParityErr);
endinterface

// File: rtl/uart_tick_gen.sv
// Divide-by-TICK_DIV counter giving a one-cycle tick; restart forces the phase back to zero.
module uart_tick_gen #(
   parameter int TICK_DIV = 27
) (
   input  logic ipClk,
   input  logic ipReset,
   input  logic ipRestart,
   output logic opTick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge ipClk) begin
      if (ipReset || ipRestart) cnt <= '0;
      else if (cnt == LAST)     cnt <= '0;
      else                      cnt <= cnt + CW'(1);
   end

   assign opTick = (cnt == LAST) && !ipRestart;
endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready TX, 16x-oversampled RX with glitch and break handling.
// Define UART_PARITY_EN to add a parity bit (even/odd via PARITY_ODD) on both directions.
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input logic   ipClk,
   input logic   ipReset,
   uart_if.slave bus
);
   localparam int TICK_DIV = calcTickDiv(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int OCW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [OCW-1:0] OVS_LAST  = OCW'(OVERSAMPLE - 1);
   localparam logic [OCW-1:0] OVS_HALF  = OCW'(OVERSAMPLE / 2 - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

   if (TICK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParam
      $error("uart_core: illegal parameter set (TICK_DIV must be >= 2)");
   end

`ifdef UART_PARITY_EN
   localparam logic PODD = 1'(PARITY_ODD);
   logic txPar, txParNext, rxPar, rxParNext, rxParErr;
`endif

   // ---------------- TX ----------------
   tTxState              txState, txStateNext;
   logic [DATA_BITS-1:0] txShift, txShiftNext;
   logic [BCW-1:0]       txBitCnt, txBitCntNext;
   logic [OCW-1:0]       txOvs, txOvsNext;
   logic                 txLine, txLineNext, txTick, txBitDone;

   uart_tick_gen #(.TICK_DIV(TICK_DIV)) uTxTick (
      .ipClk(ipClk), .ipReset(ipReset), .ipRestart(txState == TX_IDLE), .opTick(txTick));

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         txState  <= TX_IDLE;
         txShift  <= '0;
         txBitCnt <= '0;
         txOvs    <= '0;
         txLine   <= 1'b1;
`ifdef UART_PARITY_EN
         txPar    <= 1'b0;
`endif
      end else begin
         txState  <= txStateNext;
         txShift  <= txShiftNext;
         txBitCnt <= txBitCntNext;
         txOvs    <= txOvsNext;
         txLine   <= txLineNext;
`ifdef UART_PARITY_EN
         txPar    <= txParNext;
`endif
      end
   end

   // txLineNext is the level of the bit that starts with txStateNext, so opTx is a clean flop.
   always_comb begin
      txStateNext  = txState;
      txShiftNext  = txShift;
      txBitCntNext = txBitCnt;
      txOvsNext    = txOvs;
      txLineNext   = txLine;
`ifdef UART_PARITY_EN
      txParNext    = txPar;
`endif
      txBitDone = txTick && (txOvs == OVS_LAST);
      if (txTick) txOvsNext = txBitDone ? '0 : txOvs + OCW'(1);
      case (txState)
         TX_IDLE: if (bus.ipTxValid) begin
            txStateNext  = TX_START;
            txShiftNext  = bus.ipTxData;
            txBitCntNext = '0;
            txOvsNext    = '0;
            txLineNext   = 1'b0;
`ifdef UART_PARITY_EN
            txParNext    = (^bus.ipTxData) ^ PODD;
`endif
         end
         TX_START: if (txBitDone) begin
            txStateNext = TX_DATA;
            txLineNext  = txShift[0];
         end
         TX_DATA: if (txBitDone) begin
            if (txBitCnt == BIT_LAST) begin
               txBitCntNext = '0;
`ifdef UART_PARITY_EN
               txStateNext  = TX_PARITY;
               txLineNext   = txPar;
`else
               txStateNext  = TX_STOP;
               txLineNext   = 1'b1;
`endif
            end else begin
               txBitCntNext = txBitCnt + BCW'(1);
               txShiftNext  = txShift >> 1;
               txLineNext   = txShift[1];
            end
         end
         TX_PARITY: if (txBitDone) begin
            txStateNext = TX_STOP;
            txLineNext  = 1'b1;
         end
         TX_STOP: if (txBitDone) begin
            if (txBitCnt == STOP_LAST) txStateNext = TX_IDLE;
            else                       txBitCntNext = txBitCnt + BCW'(1);
         end
         default: txStateNext = TX_IDLE;
      endcase
   end

   assign bus.opTx      = txLine;
   assign bus.opTxReady = (txState == TX_IDLE);

   // ---------------- RX ----------------
   tRxState              rxState, rxStateNext;
   logic [DATA_BITS-1:0] rxShift, rxShiftNext, rxData;
   logic [BCW-1:0]       rxBitCnt, rxBitCntNext;
   logic [OCW-1:0]       rxOvs, rxOvsNext;
   logic                 rxMeta, rxSync, rxLast, rxFall, rxTick, rxSample, rxDeliver;
   logic                 rxValid, rxFrameErr;

   assign rxFall = rxLast && !rxSync;

   uart_tick_gen #(.TICK_DIV(TICK_DIV)) uRxTick (
      .ipClk(ipClk), .ipReset(ipReset), .ipRestart((rxState == RX_IDLE) && rxFall), .opTick(rxTick));

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         {rxMeta, rxSync, rxLast} <= 3'b111;
         rxState    <= RX_IDLE;
         rxShift    <= '0;
         rxBitCnt   <= '0;
         rxOvs      <= '0;
         rxData     <= '0;
         rxValid    <= 1'b0;
         rxFrameErr <= 1'b0;
`ifdef UART_PARITY_EN
         rxPar      <= 1'b0;
         rxParErr   <= 1'b0;
`endif
      end else begin
         {rxMeta, rxSync, rxLast} <= {bus.ipRx, rxMeta, rxSync};
         rxState  <= rxStateNext;
         rxShift  <= rxShiftNext;
         rxBitCnt <= rxBitCntNext;
         rxOvs    <= rxOvsNext;
         rxValid  <= rxDeliver;
`ifdef UART_PARITY_EN
         rxPar    <= rxParNext;
`endif
         if (rxDeliver) begin
            rxData     <= rxShift;
            rxFrameErr <= !rxSync;
`ifdef UART_PARITY_EN
            rxParErr   <= ((^rxShift) ^ rxPar) != PODD;
`endif
         end
      end
   end

   always_comb begin
      rxStateNext  = rxState;
      rxShiftNext  = rxShift;
      rxBitCntNext = rxBitCnt;
      rxOvsNext    = rxOvs;
      rxDeliver    = 1'b0;
`ifdef UART_PARITY_EN
      rxParNext    = rxPar;
`endif
      rxSample = rxTick && (rxOvs == OVS_LAST);
      if (rxTick) rxOvsNext = rxSample ? '0 : rxOvs + OCW'(1);
      case (rxState)
         RX_IDLE: if (rxFall) begin
            rxStateNext  = RX_START;
            rxOvsNext    = '0;
            rxBitCntNext = '0;
         end
         // Half a bit after the edge: a high line means a glitch; otherwise re-phase to mid-bit.
         RX_START: if (rxTick && rxOvs == OVS_HALF) begin
            if (rxSync) rxStateNext = RX_IDLE;
            else begin
               rxStateNext = RX_DATA;
               rxOvsNext   = '0;
            end
         end
         RX_DATA: if (rxSample) begin
            rxShiftNext = {rxSync, rxShift[DATA_BITS-1:1]};
            if (rxBitCnt == BIT_LAST) begin
               rxBitCntNext = '0;
`ifdef UART_PARITY_EN
               rxStateNext  = RX_PARITY;
`else
               rxStateNext  = RX_STOP;
`endif
            end else rxBitCntNext = rxBitCnt + BCW'(1);
         end
         RX_PARITY: if (rxSample) begin
`ifdef UART_PARITY_EN
            rxParNext   = rxSync;
`endif
            rxStateNext = RX_STOP;
         end
         RX_STOP: if (rxSample) begin
            rxDeliver   = 1'b1;
            rxStateNext = rxSync ? RX_IDLE : RX_WAIT_HIGH;
         end
         RX_WAIT_HIGH: if (rxSync) rxStateNext = RX_IDLE;
         default: rxStateNext = RX_IDLE;
      endcase
   end

   assign bus.opRxData     = rxData;
   assign bus.opRxValid    = rxValid;
   assign bus.opRxFrameErr = rxFrameErr;
`ifdef UART_PARITY_EN
   assign bus.opRxParityErr = rxParErr;
`else
   assign bus.opRxParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-level model of the serial line plus an RX scoreboard.
module tb_uart_core;
   localparam int CLK_FREQ = 50_000_000, BAUD = 115_200, DB = 8, SB = 1, OVS = 16, PODD = 0;
   localparam int BIT = ((CLK_FREQ + BAUD * OVS / 2) / (BAUD * OVS)) * OVS;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 1 + DB + PB + SB;
   localparam int FRAME = NBITS * BIT;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          frameErr;
      logic          parityErr;
   } tRxExp;

   logic   clk = 1'b0, rst = 1'b1, loop = 1'b0, rxDrv = 1'b1;
   int     errCnt = 0, chkCnt = 0, cyc = 0, rxCnt = 0, lastAcc = 0, c0;
   logic [DB-1:0] d;
   tRxExp  expQ[$];

   uart_if #(.DATA_BITS(DB)) uif();
   assign uif.ipRx = loop ? uif.opTx : rxDrv;

   uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB),
               .OVERSAMPLE(OVS), .PARITY_ODD(PODD)) dut (
      .ipClk(clk), .ipReset(rst), .bus(uif));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line level of bit k of a frame: start, data LSB first, optional parity, stop.
   function automatic logic frameBit(input logic [DB-1:0] v, input int k, input logic parFlip);
      if (k == 0) return 1'b0;
      if (k <= DB) return v[k-1];
      if (PB == 1 && k == DB + 1) return (^v) ^ 1'(PODD) ^ parFlip;
      return 1'b1;
   endfunction

   task automatic expPush(input logic [DB-1:0] v, input logic fe, input logic pe);
      expQ.push_back(tRxExp'{data: v, frameErr: fe, parityErr: pe});
   endtask

   always @(negedge clk) begin
      if (!rst && uif.opRxValid) begin
         rxCnt++;
         if (expQ.size() == 0) chk("rxUnexpectedStrobe", uif.opRxValid, 1'b0);
         else begin
            tRxExp e;
            e = expQ.pop_front();
            chk("rxData", uif.opRxData, e.data);
            chk("rxFrameErr", uif.opRxFrameErr, e.frameErr);
            chk("rxParityErr", uif.opRxParityErr, e.parityErr);
         end
      end
   end

   // Offer v and wait for acceptance; chain=1 also checks the accept spacing to the previous frame.
   task automatic txNext(input logic [DB-1:0] v, input logic chain);
      int n = 0;
      uif.ipTxData  = v;
      uif.ipTxValid = 1'b1;
      while (!uif.opTxReady && n < 2 * FRAME) begin @(negedge clk); n++; end
      chk("txReadyWait", uif.opTxReady, 1'b1);
      @(posedge clk); #1;
      if (chain) chk("txGapless", cyc - lastAcc, FRAME + 1);
      lastAcc = cyc;
   endtask

   task automatic txCheck(input logic [DB-1:0] v);
      for (int t = 1; t <= FRAME + 1; t++) begin
         @(negedge clk);
         if (t <= FRAME && (t % BIT == 1 || t % BIT == 0))
            chk($sformatf("txBit%0d", (t - 1) / BIT), uif.opTx, frameBit(v, (t - 1) / BIT, 1'b0));
         if (t == 1 || t == FRAME || t == FRAME + 1)
            chk($sformatf("txReady@%0d", t), uif.opTxReady, t == FRAME + 1);
      end
   endtask

   task automatic rxSend(input logic [DB-1:0] v, input logic stopLow, input logic parFlip);
      for (int k = 0; k < NBITS; k++) begin
         rxDrv = (stopLow && k >= NBITS - SB) ? 1'b0 : frameBit(v, k, parFlip);
         repeat (BIT) @(posedge clk);
         #1;
      end
   endtask

   task automatic waitRx(input string tag, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin @(negedge clk); n++; end
      chk(tag, expQ.size(), 0);
   endtask

   initial begin
      uif.ipTxData  = '0;
      uif.ipTxValid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstTx", uif.opTx, 1'b1);
      chk("rstTxReady", uif.opTxReady, 1'b1);
      chk("rstRxValid", uif.opRxValid, 1'b0);
      chk("rstRxData", uif.opRxData, 0);
      chk("rstFrameErr", uif.opRxFrameErr, 1'b0);
      chk("rstParityErr", uif.opRxParityErr, 1'b0);

      // Single TX frame; data input is scrambled after accept
      txNext(8'h55, 1'b0);
      uif.ipTxValid = 1'b0;
      uif.ipTxData  = 8'hAA;
      txCheck(8'h55);

      // Loopback, back-to-back frames, then a random burst
      loop = 1'b1;
      expPush(8'hA3, 1'b0, 1'b0);
      expPush(8'h0F, 1'b0, 1'b0);
      txNext(8'hA3, 1'b0);
      txNext(8'h0F, 1'b1);
      uif.ipTxValid = 1'b0;
      waitRx("loopRx", 2 * FRAME);
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom_range(0, 255));
         expPush(d, 1'b0, 1'b0);
         txNext(d, i != 0);
      end
      uif.ipTxValid = 1'b0;
      waitRx("loopRandRx", 2 * FRAME);
      loop = 1'b0;
      @(negedge clk);

      // Short low glitch must be rejected, then a clean frame
      c0 = rxCnt;
      rxDrv = 1'b0;
      repeat (100) @(posedge clk);
      #1 rxDrv = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      chk("glitchNoStrobe", rxCnt - c0, 0);
      expPush(8'h3C, 1'b0, 1'b0);
      rxSend(8'h3C, 1'b0, 1'b0);
      waitRx("rx3C", BIT);
      d = 8'($urandom_range(0, 255));
      expPush(d, 1'b0, 1'b0);
      rxSend(d, 1'b0, 1'b0);
      waitRx("rxRand", BIT);

      // Framing error followed by a long break
      c0 = rxCnt;
      expPush(8'h81, 1'b1, 1'b0);
      rxSend(8'h81, 1'b1, 1'b0);
      repeat (20 * BIT) @(negedge clk);
      chk("breakOneStrobe", rxCnt - c0, 1);
      rxDrv = 1'b1;
      repeat (BIT) @(negedge clk);
      chk("breakRelease", rxCnt - c0, 1);
      chk("breakQueue", expQ.size(), 0);

`ifdef UART_PARITY_EN
      txNext(8'h07, 1'b0);
      uif.ipTxValid = 1'b0;
      txCheck(8'h07);
      expPush(8'h5A, 1'b0, 1'b1);
      rxSend(8'h5A, 1'b0, 1'b1);
      waitRx("rxParCorrupt", BIT);
`endif

      // Reset during data bit 3 of simultaneous TX and RX frames
      c0 = rxCnt;
      txNext(8'hE5, 1'b0);
      uif.ipTxValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rxDrv = frameBit(8'h5B, k, 1'b0);
         repeat (BIT) @(posedge clk);
         #1;
      end
      rxDrv = frameBit(8'h5B, 4, 1'b0);
      repeat (BIT / 2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      rxDrv = 1'b1;
      @(negedge clk);
      chk("midRstTx", uif.opTx, 1'b1);
      chk("midRstTxReady", uif.opTxReady, 1'b1);
      chk("midRstRxValid", uif.opRxValid, 1'b0);
      repeat (2 * BIT) @(negedge clk);
      chk("midRstNoStrobe", rxCnt - c0, 0);
      chk("midRstTxIdle", uif.opTx, 1'b1);
      expPush(8'hC6, 1'b0, 1'b0);
      rxSend(8'hC6, 1'b0, 1'b0);
      waitRx("rxC6", BIT);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule
